pcl_bitbang_host: RTL and testbench
===================================

// Module: pcl_bitbang_host
// PURPOSE
//  Initiator side of the bitbang byte protocol. Turns one local request into the
//  command byte sequence (READ/WRITE/PING/ECHO), drives it over a byte TX/RX link,
//  collects and checks the reply, and returns one response per request.
//  Used for board-to-board I/O control and for loopback self-test against the responder.
// PARAMETERS
//  IO_NUM_OF       10       remote I/O pin count; DATA_BYTES = ceil(IO_NUM_OF/8)
//  TIMEOUT_CYCLES  1000000  max in_clk cycles spent waiting for any single tx_done/rx_done
// PORTS
//  in_clk     in   1          clock; single clock domain
//  in_rst     in   1          asynchronous reset, active-high
//  req_valid  in   1          request present
//  req_ready  out  1          high only in IDLE
//  req_op     in   3          0 READ, 1 WRITE_DIR, 2 WRITE_OUT, 3 PING, 4 ECHO; 5-7 illegal
//  req_data   in   IO_NUM_OF  value for WRITE_DIR/WRITE_OUT
//  req_echo   in   8          character for ECHO
//  rsp_valid  out  1          1-cycle pulse, one per accepted request
//  rsp_data   out  IO_NUM_OF  READ: pin values; ECHO: returned char in [7:0]; else 0
//  rsp_err    out  2          0 OK, 1 TIMEOUT, 2 BAD_REPLY, 3 BAD_OP; valid with rsp_valid
//  data_tx    out  8          byte to transmit; stable from tx_trig until tx_done
//  tx_trig    out  1          1-cycle pulse: start TX of data_tx
//  tx_done    in   1          TX byte complete
//  rx_trig    out  1          1-cycle pulse: arm RX of next byte
//  data_rx    in   8          received byte; valid when rx_done
//  rx_done    in   1          RX byte complete
// BEHAVIOUR
//  Reset: state IDLE; tx_trig, rx_trig, rsp_valid, data_tx, rsp_data, rsp_err = 0;
//   req_ready = 1. Reset mid-transaction aborts silently: no rsp_valid.
//  Sequences (multi-byte data MSB byte first, byte index DATA_BYTES-1 down to 0):
//   READ:      TX 0x00; RX DATA_BYTES bytes; rsp_data = concatenation truncated to IO_NUM_OF.
//   WRITE_DIR: TX 0x01, 0x00, data bytes; RX 1 byte, must equal 0x02.
//   WRITE_OUT: TX 0x01, 0x01, data bytes; RX 1 byte, must equal 0x02.
//   PING:      TX 0x04; RX 1 byte, must equal 0x02.
//   ECHO:      TX 0x03, req_echo; RX 1 byte, must equal req_echo.
//   Data byte i = (req_data >> 8*i) & 8'hFF; bits above IO_NUM_OF sent as 0.
//  States: IDLE -> TX_BYTE -> (next TX_BYTE | RX_BYTE) -> (next RX_BYTE | RESP) -> IDLE.
//   IDLE: accept on req_valid&&req_ready (cycle T); latch op/data/echo.
//    Illegal op: RESP with BAD_OP at T+1; no link traffic.
//   TX_BYTE: tx_trig pulses at T+1 with data_tx valid. The next byte's tx_trig follows
//    the cycle after tx_done is sampled. After the last tx_done, go to RX_BYTE.
//   RX_BYTE: rx_trig pulses on entry. On rx_done, capture data_rx and shift it in
//    (READ), or compare it (others). Re-arm until all reply bytes are taken.
//   RESP: rsp_valid=1 for exactly one cycle, then IDLE (req_ready=1 the following cycle).
//   Latency: final rx_done at cycle R -> rsp_valid at R+1.
//  Timeout: wait counter clears at each tx_trig/rx_trig. If it reaches TIMEOUT_CYCLES
//   with no done -> RESP with TIMEOUT, rsp_data=0.
//   done and expiry in the same cycle: done wins.
//  BAD_REPLY: mismatching reply byte -> RESP with BAD_REPLY, rsp_data=received byte.
//  tx_done/rx_done are ignored outside the state waiting for them.
//   Stray rx_done during TX_BYTE is dropped.
//  rsp_data/rsp_err hold their value until the next RESP.
// TESTING
//  T1 READ, IO=10: responder returns 0x02,0xA5 -> TX 0x00; rsp_data=10'h2A5, err=0.
//  T2 WRITE_OUT, data=10'h3C1 -> TX 0x01,0x01,0x03,0xC1; reply 0x02 -> err=0, rsp_data=0.
//  T3 ECHO 'Z': reply 0x5A -> err=0, rsp_data[7:0]=0x5A; reply 0x41 -> err=2, rsp_data=0x41.
//  T4 PING with rx_done never asserted, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after rx_trig,
//     err=1; rx_done in the expiry cycle -> err=0.
//  T5 req_op=6 -> rsp_valid at T+1, err=3, no tx_trig; back-to-back requests each get one rsp.
//  T6 in_rst asserted mid-WRITE after 2 bytes -> outputs return to reset values immediately,
//     no rsp_valid; the next PING completes normally.
//  Loopback with pcl_bitbang: WRITE_DIR 0x3FF, WRITE_OUT 0x155, READ -> 0x155.

Source files
------------

// File: rtl/pcl_bitbang_host.sv
// Initiator for the bitbang byte protocol: turns one request into a
// command byte sequence, collects and checks the reply, returns one response.
module pcl_bitbang_host #(
    parameter int IO_NUM_OF      = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [IO_NUM_OF-1:0] req_data,
    input  logic [7:0]           req_echo,
    output logic                 rsp_valid,
    output logic [IO_NUM_OF-1:0] rsp_data,
    output logic [1:0]           rsp_err,
    output logic [7:0]           data_tx,
    output logic                 tx_trig,
    input  logic                 tx_done,
    output logic                 rx_trig,
    input  logic [7:0]           data_rx,
    input  logic                 rx_done
);

    localparam int DB = (IO_NUM_OF + 7) / 8;
    localparam int DW = 8 * DB;
    localparam int IW = $clog2(DB + 3);
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_READ = 3'd0;
    localparam logic [2:0] OP_WDIR = 3'd1;
    localparam logic [2:0] OP_WOUT = 3'd2;
    localparam logic [2:0] OP_PING = 3'd3;
    localparam logic [2:0] OP_ECHO = 3'd4;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_BAD_REP = 2'd2;
    localparam logic [1:0] ERR_BAD_OP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TX,
        S_RX,
        S_RESP
    } state_t;

    state_t state, state_n;

    logic [IW-1:0]        idx, idx_n;
    logic [IW-1:0]        rx_cnt, rx_cnt_n;
    logic [WW-1:0]        wait_cnt, wait_n;
    logic [2:0]           op_q, op_n;
    logic [DW-1:0]        data_q, data_n;
    logic [7:0]           echo_q, echo_n;
    logic [DW-1:0]        rx_shift, rx_shift_n;
    logic [7:0]           data_tx_n;
    logic                 tx_trig_n;
    logic                 rx_trig_n;
    logic                 rsp_valid_n;
    logic [IO_NUM_OF-1:0] rsp_data_n;
    logic [1:0]           rsp_err_n;

    // Byte i of the command sequence for an op; data bytes go MSB first.
    function automatic logic [7:0] byte_at(
        input logic [2:0]    op,
        input logic [DW-1:0] d,
        input logic [7:0]    e,
        input logic [IW-1:0] i
    );
        logic [7:0] b;
        int k;
        b = 8'h00;
        k = DB + 1 - int'(i);
        case (op)
            OP_READ: b = 8'h00;
            OP_PING: b = 8'h04;
            OP_ECHO: b = (i == IW'(0)) ? 8'h03 : e;
            OP_WDIR, OP_WOUT: begin
                if (i == IW'(0))
                    b = 8'h01;
                else if (i == IW'(1))
                    b = {7'd0, op == OP_WOUT};
                else
                    b = d[8*k +: 8];
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Index of the last byte transmitted for an op.
    function automatic logic [IW-1:0] tx_last(input logic [2:0] op);
        logic [IW-1:0] r;
        case (op)
            OP_ECHO:          r = IW'(1);
            OP_WDIR, OP_WOUT: r = IW'(DB + 1);
            default:          r = IW'(0);
        endcase
        return r;
    endfunction

    logic [IW-1:0] rx_last;
    logic [7:0]    exp_reply;

    assign rx_last   = (op_q == OP_READ) ? IW'(DB - 1) : IW'(0);
    assign exp_reply = (op_q == OP_ECHO) ? echo_q : 8'h02;
    assign req_ready = (state == S_IDLE);

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        rx_cnt_n    = rx_cnt;
        wait_n      = wait_cnt;
        op_n        = op_q;
        data_n      = data_q;
        echo_n      = echo_q;
        rx_shift_n  = rx_shift;
        data_tx_n   = data_tx;
        tx_trig_n   = 1'b0;
        rx_trig_n   = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    op_n   = req_op;
                    data_n = DW'(req_data);
                    echo_n = req_echo;
                    if (req_op <= OP_ECHO) begin
                        state_n   = S_TX;
                        idx_n     = '0;
                        wait_n    = '0;
                        tx_trig_n = 1'b1;
                        data_tx_n = byte_at(req_op, DW'(req_data),
                                            req_echo, IW'(0));
                    end else begin
                        state_n     = S_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_data_n  = '0;
                        rsp_err_n   = ERR_BAD_OP;
                    end
                end
            end
            S_TX: begin
                if (tx_done) begin
                    wait_n = '0;
                    if (idx == tx_last(op_q)) begin
                        state_n    = S_RX;
                        rx_cnt_n   = '0;
                        rx_shift_n = '0;
                        rx_trig_n  = 1'b1;
                    end else begin
                        idx_n     = idx + 1'b1;
                        tx_trig_n = 1'b1;
                        data_tx_n = byte_at(op_q, data_q, echo_q,
                                            idx + 1'b1);
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = '0;
                    rsp_err_n   = ERR_TIMEOUT;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            S_RX: begin
                if (rx_done) begin
                    if (op_q == OP_READ) begin
                        rx_shift_n      = rx_shift << 8;
                        rx_shift_n[7:0] = data_rx;
                        if (rx_cnt == rx_last) begin
                            state_n     = S_RESP;
                            rsp_valid_n = 1'b1;
                            rsp_data_n  = rx_shift_n[IO_NUM_OF-1:0];
                            rsp_err_n   = ERR_OK;
                        end else begin
                            rx_cnt_n  = rx_cnt + 1'b1;
                            wait_n    = '0;
                            rx_trig_n = 1'b1;
                        end
                    end else if (data_rx == exp_reply) begin
                        state_n     = S_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = ERR_OK;
                        rsp_data_n  = (op_q == OP_ECHO) ?
                                      IO_NUM_OF'(data_rx) : '0;
                    end else begin
                        state_n     = S_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = ERR_BAD_REP;
                        rsp_data_n  = IO_NUM_OF'(data_rx);
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = '0;
                    rsp_err_n   = ERR_TIMEOUT;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Datapath and registered link/response outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            idx       <= '0;
            rx_cnt    <= '0;
            wait_cnt  <= '0;
            op_q      <= '0;
            data_q    <= '0;
            echo_q    <= '0;
            rx_shift  <= '0;
            data_tx   <= '0;
            tx_trig   <= 1'b0;
            rx_trig   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= '0;
        end else begin
            idx       <= idx_n;
            rx_cnt    <= rx_cnt_n;
            wait_cnt  <= wait_n;
            op_q      <= op_n;
            data_q    <= data_n;
            echo_q    <= echo_n;
            rx_shift  <= rx_shift_n;
            data_tx   <= data_tx_n;
            tx_trig   <= tx_trig_n;
            rx_trig   <= rx_trig_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_pcl_bitbang_host.sv
// Directed bench for pcl_bitbang_host: plays the responder side by hand
// and checks each response against hand-computed values.
module tb_pcl_bitbang_host;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [9:0] req_data;
    logic [7:0] req_echo;
    logic       rsp_valid;
    logic [9:0] rsp_data;
    logic [1:0] rsp_err;
    logic [7:0] data_tx;
    logic       tx_trig;
    logic       tx_done;
    logic       rx_trig;
    logic [7:0] data_rx;
    logic       rx_done;

    int total = 0;
    int bad   = 0;
    int cnt;
    int trigs;

    pcl_bitbang_host #(
        .IO_NUM_OF      (10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .in_clk    (clk),
        .in_rst    (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_echo  (req_echo),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .data_tx   (data_tx),
        .tx_trig   (tx_trig),
        .tx_done   (tx_done),
        .rx_trig   (rx_trig),
        .data_rx   (data_rx),
        .rx_done   (rx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [9:0] d,
                        input logic [7:0] e);
        req_op    = op;
        req_data  = d;
        req_echo  = e;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] b);
        int n = 0;
        while (tx_trig !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, ".trig"}, 32'(tx_trig), 32'd1);
        chk({tag, ".byte"}, 32'(data_tx), 32'(b));
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] b);
        int n = 0;
        while (rx_trig !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, ".rxtrig"}, 32'(rx_trig), 32'd1);
        cyc();
        data_rx = b;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [9:0] d,
                             input logic [1:0] e);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".data"}, 32'(rsp_data), 32'(d));
        chk({tag, ".err"}, 32'(rsp_err), 32'(e));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_data  = '0;
        req_echo  = '0;
        tx_done   = 1'b0;
        rx_done   = 1'b0;
        data_rx   = '0;
        cyc();
        cyc();
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.tx_trig", 32'(tx_trig), 32'd0);
        chk("rst.rx_trig", 32'(rx_trig), 32'd0);
        chk("rst.data_tx", 32'(data_tx), 32'd0);
        chk("rst.rsp_data", 32'(rsp_data), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        cyc();

        // READ: two reply bytes MSB first
        send(3'd0, 10'h0, 8'h0);
        chk("t1.lat", 32'(tx_trig), 32'd1);
        expect_tx("t1.tx0", 8'h00);
        expect_rx("t1.rx0", 8'h02);
        expect_rx("t1.rx1", 8'hA5);
        check_rsp("t1", 10'h2A5, 2'd0);
        cyc();
        chk("t1.pulse", 32'(rsp_valid), 32'd0);
        chk("t1.ready", 32'(req_ready), 32'd1);

        // WRITE_OUT 0x3C1
        send(3'd2, 10'h3C1, 8'h0);
        expect_tx("t2.tx0", 8'h01);
        expect_tx("t2.tx1", 8'h01);
        expect_tx("t2.tx2", 8'h03);
        expect_tx("t2.tx3", 8'hC1);
        expect_rx("t2.rx", 8'h02);
        check_rsp("t2", 10'h0, 2'd0);
        cyc();

        // WRITE_DIR 0x3FF
        send(3'd1, 10'h3FF, 8'h0);
        expect_tx("wd.tx0", 8'h01);
        expect_tx("wd.tx1", 8'h00);
        expect_tx("wd.tx2", 8'h03);
        expect_tx("wd.tx3", 8'hFF);
        expect_rx("wd.rx", 8'h02);
        check_rsp("wd", 10'h0, 2'd0);
        cyc();

        // ECHO 'Z' good and bad replies
        send(3'd4, 10'h0, 8'h5A);
        expect_tx("t3a.tx0", 8'h03);
        expect_tx("t3a.tx1", 8'h5A);
        expect_rx("t3a.rx", 8'h5A);
        check_rsp("t3a", 10'h05A, 2'd0);
        cyc();
        send(3'd4, 10'h0, 8'h5A);
        expect_tx("t3b.tx0", 8'h03);
        expect_tx("t3b.tx1", 8'h5A);
        expect_rx("t3b.rx", 8'h41);
        check_rsp("t3b", 10'h041, 2'd2);
        cyc();

        // PING with a wrong reply, then response hold
        send(3'd3, 10'h0, 8'h0);
        expect_tx("pb.tx", 8'h04);
        expect_rx("pb.rx", 8'h07);
        check_rsp("pb", 10'h007, 2'd2);
        cyc();
        cyc();
        chk("pb.hold", 32'(rsp_data), 32'h007);

        // PING, no rx_done: timeout 16 cycles after rx_trig
        send(3'd3, 10'h0, 8'h0);
        expect_tx("t4a.tx", 8'h04);
        chk("t4a.rxtrig", 32'(rx_trig), 32'd1);
        cnt = 0;
        repeat (15) begin
            cyc();
            cnt += int'(rsp_valid);
        end
        chk("t4a.early", 32'(cnt), 32'd0);
        cyc();
        check_rsp("t4a", 10'h0, 2'd1);
        cyc();

        // PING, rx_done lands in the expiry cycle: done wins
        send(3'd3, 10'h0, 8'h0);
        expect_tx("t4b.tx", 8'h04);
        chk("t4b.rxtrig", 32'(rx_trig), 32'd1);
        repeat (15) cyc();
        data_rx = 8'h02;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
        check_rsp("t4b", 10'h0, 2'd0);
        cyc();

        // PING, no tx_done: timeout 16 cycles after tx_trig
        send(3'd3, 10'h0, 8'h0);
        chk("t4c.trig", 32'(tx_trig), 32'd1);
        repeat (16) cyc();
        check_rsp("t4c", 10'h0, 2'd1);
        cyc();

        // illegal op, then back-to-back illegal ops
        send(3'd6, 10'h0, 8'h0);
        check_rsp("t5", 10'h0, 2'd3);
        chk("t5.notx", 32'(tx_trig), 32'd0);
        cyc();
        req_op    = 3'd7;
        req_valid = 1'b1;
        cnt       = 0;
        trigs     = 0;
        repeat (6) begin
            cyc();
            cnt   += int'(rsp_valid);
            trigs += int'(tx_trig);
        end
        req_valid = 1'b0;
        chk("t5.b2b_rsp", 32'(cnt), 32'd3);
        chk("t5.b2b_notx", 32'(trigs), 32'd0);
        cyc();

        // reset in the middle of a WRITE
        send(3'd2, 10'h3C1, 8'h0);
        expect_tx("t6.tx0", 8'h01);
        expect_tx("t6.tx1", 8'h01);
        rst = 1'b1;
        #1;
        chk("t6.tx_trig", 32'(tx_trig), 32'd0);
        chk("t6.data_tx", 32'(data_tx), 32'd0);
        chk("t6.ready", 32'(req_ready), 32'd1);
        chk("t6.rsp_valid", 32'(rsp_valid), 32'd0);
        cyc();
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin
            cyc();
            cnt += int'(rsp_valid) + int'(tx_trig);
        end
        chk("t6.quiet", 32'(cnt), 32'd0);
        send(3'd3, 10'h0, 8'h0);
        expect_tx("t6p.tx", 8'h04);
        expect_rx("t6p.rx", 8'h02);
        check_rsp("t6p", 10'h0, 2'd0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
